output_gain_stage: RTL

- Downstream of the IIR lowpass in the channel strip. Applies a programmable output gain to the filter's signed 16-bit samples.
- Gain is fixed-point with 10 fractional bits, matching the filter's ×1024 coefficient scaling; 1024 = unity.
- Gain changes ramp in small steps, one step per sample, to avoid zipper noise.
- Results saturate to 16 bits, each saturation event is flagged, and the result is presented to the next stage with a valid strobe.

---
 rtl/output_gain_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/output_gain_stage.sv
// Output gain stage: ramped Q6.10 gain applied to signed 16-bit samples,
// two-stage multiply / floor-shift / saturate pipeline with clip flag.
module output_gain_stage #(
    parameter int GAIN_FRAC  = 10,
    parameter int RAMP_STEP  = 4,
    parameter int RESET_GAIN = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic [15:0] gain_target,
    input  logic        gain_load,
    output logic [15:0] sample_out,
    output logic        out_valid,
    output logic        clip,
    output logic [15:0] gain_current,
    output logic        ramping
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    localparam logic [15:0]        RESET_GAIN_C = RESET_GAIN[15:0];
    localparam logic [15:0]        STEP_C       = RAMP_STEP[15:0];
    localparam logic signed [32:0] SAT_MAX_C    = 33'sd32767;
    localparam logic signed [32:0] SAT_MIN_C    = -33'sd32768;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [15:0]        gain_r;
    logic [15:0]        gain_nxt_s;
    logic [15:0]        target_r;
    logic [15:0]        target_nxt_s;
    logic               ramping_r;

    logic signed [32:0] mul_a_s;
    logic signed [32:0] mul_b_s;
    logic signed [32:0] prod_s;
    logic signed [32:0] prod_r;
    logic               v1_r;

    logic signed [32:0] shifted_s;
    logic [16:0]        sat_s;
    logic [15:0]        sample_out_r;
    logic               out_valid_r;
    logic               clip_r;

    // One clamped ramp step from cur toward tgt; never overshoots.
    function automatic logic [15:0] ramp_toward(input logic [15:0] cur, input logic [15:0] tgt);
        logic [15:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            if (diff > STEP_C) begin
                return cur + STEP_C;
            end else begin
                return tgt;
            end
        end else if (cur > tgt) begin
            diff = cur - tgt;
            if (diff > STEP_C) begin
                return cur - STEP_C;
            end else begin
                return tgt;
            end
        end else begin
            return cur;
        end
    endfunction

    // Saturate to signed 16 bits; MSB of the result is the clip flag.
    function automatic logic [16:0] sat16(input logic signed [32:0] v);
        if (v > SAT_MAX_C) begin
            return {1'b1, 16'h7FFF};
        end else if (v < SAT_MIN_C) begin
            return {1'b1, 16'h8000};
        end else begin
            return {1'b0, v[15:0]};
        end
    endfunction

    // Gain control: target latch, per-sample ramp step and next-state decode.
    always_comb begin
        target_nxt_s = target_r;
        gain_nxt_s   = gain_r;
        state_nxt_s  = state_r;
        if (gain_load) begin
            target_nxt_s = gain_target;
        end else begin
            target_nxt_s = target_r;
        end
        case (state_r)
            ST_IDLE: begin
                gain_nxt_s = gain_r;
            end
            ST_RAMP: begin
                // A load in the same cycle redirects this step toward the new target.
                if (sample_valid) begin
                    gain_nxt_s = ramp_toward(gain_r, target_nxt_s);
                end else begin
                    gain_nxt_s = gain_r;
                end
            end
            default: begin
                gain_nxt_s = gain_r;
            end
        endcase
        if (target_nxt_s != gain_nxt_s) begin
            state_nxt_s = ST_RAMP;
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // Gain control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            gain_r    <= RESET_GAIN_C;
            target_r  <= RESET_GAIN_C;
            ramping_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            gain_r    <= gain_nxt_s;
            target_r  <= target_nxt_s;
            ramping_r <= (state_nxt_s == ST_RAMP);
        end
    end

    // Stage 1 operands: gain is treated as unsigned by zero-extending it.
    always_comb begin
        mul_a_s = {{17{sample_in[15]}}, sample_in};
        mul_b_s = {17'd0, gain_r};
        prod_s  = mul_a_s * mul_b_s;
    end

    // Stage 1 register: product of the sample and the pre-update gain.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_r <= 33'sd0;
            v1_r   <= 1'b0;
        end else begin
            prod_r <= sample_valid ? prod_s : prod_r;
            v1_r   <= sample_valid;
        end
    end

    // Stage 2 arithmetic: arithmetic shift floors toward minus infinity.
    always_comb begin
        shifted_s = prod_r >>> GAIN_FRAC;
        sat_s     = sat16(shifted_s);
    end

    // Stage 2 register: output holds its last value between valid results.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out_r <= 16'd0;
            out_valid_r  <= 1'b0;
            clip_r       <= 1'b0;
        end else begin
            out_valid_r <= v1_r;
            if (v1_r) begin
                sample_out_r <= sat_s[15:0];
                clip_r       <= sat_s[16];
            end else begin
                sample_out_r <= sample_out_r;
                clip_r       <= 1'b0;
            end
        end
    end

    assign sample_out   = sample_out_r;
    assign out_valid    = out_valid_r;
    assign clip         = clip_r;
    assign gain_current = gain_r;
    assign ramping      = ramping_r;

endmodule
